// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core pipeline control logic: write-back select
// encodings, forwarding-select encodings and the per-stage metadata record
// carried by the hazard/forwarding shadow pipeline.
package core_ctrl_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Instruction metadata travelling alongside each shadow stage; the stage
  // valid bit is kept as a separate control register.
  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              regwen;
    logic [1:0]        wbsel;
  } stage_meta_t;

  // A stage can supply or block an operand only if it will really write a
  // non-x0 register.
  function automatic logic is_wr_cand(input logic vld, input stage_meta_t m);
    return vld && m.regwen && (m.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one EX-stage source register. MEM beats WB
// because it holds the younger result; a load sitting in MEM has no data yet
// and therefore never forwards from MEM.
module fwd_select
  import core_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              mem_vld,
  input  stage_meta_t       mem_meta,
  input  logic              wb_vld,
  input  stage_meta_t       wb_meta,
  output logic [1:0]        sel
);

  // Priority pick: MEM candidate, then WB candidate, else register file.
  always_comb begin
    sel = FWD_RF;
    if (is_wr_cand(wb_vld, wb_meta) && (wb_meta.rd == src))
      sel = FWD_WB;
    if (is_wr_cand(mem_vld, mem_meta) && (mem_meta.rd == src) &&
        (mem_meta.wbsel != WB_MEM))
      sel = FWD_MEM;
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage core. Shadows the
// write-back metadata through EX/MEM/WB and derives forwarding selects,
// load-use stall, redirect flush, and hazard performance counters.
module hazard_forward_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_regwen,
  input  logic [1:0]       id_wbsel,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_meta_t id_meta;
  stage_meta_t ex_p0;
  stage_meta_t mem_p1;
  stage_meta_t wb_p2;
  logic        vld_p0;
  logic        vld_p1;
  logic        vld_p2;
  logic        load_use;

  // Pack the ID-stage decode into the shadow metadata record.
  always_comb begin
    id_meta        = '0;
    id_meta.rs1    = id_rs1;
    id_meta.rs2    = id_rs2;
    id_meta.rd     = id_rd;
    id_meta.regwen = id_regwen;
    id_meta.wbsel  = id_wbsel;
  end

  // A load in EX whose result the ID instruction needs next cycle.
  always_comb begin
    load_use = id_valid && is_wr_cand(vld_p0, ex_p0) && (ex_p0.wbsel == WB_MEM) &&
               ((id_use_rs1 && (ex_p0.rd == id_rs1)) ||
                (id_use_rs2 && (ex_p0.rd == id_rs2)));
  end

  // Hazard resolution: memory freeze, then redirect, then load-use.
  always_comb begin
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    if (mem_busy) begin
      stall_if_id = 1'b1;
    end else if (ex_redirect) begin
      flush_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end else if (load_use) begin
      stall_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end
  end

  fwd_select u_fwd_a (
    .src      (ex_p0.rs1),
    .mem_vld  (vld_p1),
    .mem_meta (mem_p1),
    .wb_vld   (vld_p2),
    .wb_meta  (wb_p2),
    .sel      (fwd_a_sel)
  );

  fwd_select u_fwd_b (
    .src      (ex_p0.rs2),
    .mem_vld  (vld_p1),
    .mem_meta (mem_p1),
    .wb_vld   (vld_p2),
    .wb_meta  (wb_p2),
    .sel      (fwd_b_sel)
  );

  // Control state: stage valids and counters, frozen while memory is busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!mem_busy) begin
      // ---- ID -> EX -> MEM -> WB ----
      vld_p2 <= vld_p1;
      vld_p1 <= vld_p0;
      vld_p0 <= id_valid & ~bubble_id_ex;
      if (ex_redirect)
        flush_cnt <= flush_cnt + CNT_W'(1);
      else if (load_use)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Metadata shadow registers; qualified by the valids, so no reset needed.
  always_ff @(posedge clk) begin
    if (!mem_busy) begin
      // ---- ID -> EX -> MEM -> WB ----
      wb_p2  <= mem_p1;
      mem_p1 <= ex_p0;
      ex_p0  <= id_meta;
    end
  end

endmodule
